// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Purpose : shared types and constants for the LEGv8 fetch front end.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } fetch_state_t;

  // Architectural NOP, inserted into IF/ID for every bubble
  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 21;
  localparam int PC_INC  = 4;

endpackage : cpu_pkg

// File: rtl/ifid_pipe_reg.sv
// -----------------------------------------------------------------------------
// ifid_pipe_reg
// Purpose : IF/ID pipeline register with hold and bubble control.
// Ports   :
//   clk        in   clock, all state on posedge
//   reset      in   synchronous active-high reset
//   en         in   1 = load this edge, 0 = hold contents
//   bubble     in   with en: load NOP / valid=0, keep stored PC
//   d_pc       in   PC of the incoming instruction
//   d_instr    in   incoming instruction word
//   q_pc       out  held PC
//   q_instr    out  held instruction
//   q_valid    out  1 = real instruction, 0 = bubble
// -----------------------------------------------------------------------------
module ifid_pipe_reg
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               bubble,
  input  logic [ADDR_W-1:0]  d_pc,
  input  logic [INSTR_W-1:0] d_instr,
  output logic [ADDR_W-1:0]  q_pc,
  output logic [INSTR_W-1:0] q_instr,
  output logic               q_valid
);

  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= '0;
      r_instr <= INSTR_W'(NOP_INSTR);
      r_valid <= 1'b0;
    end else if (en) begin
      if (bubble) begin
        // PC of the squashed slot is left as-is
        r_instr <= INSTR_W'(NOP_INSTR);
        r_valid <= 1'b0;
      end else begin
        r_pc    <= d_pc;
        r_instr <= d_instr;
        r_valid <= 1'b1;
      end
    end
  end

  assign q_pc    = r_pc;
  assign q_instr = r_instr;
  assign q_valid = r_valid;

endmodule : ifid_pipe_reg

// File: rtl/instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage
// Purpose : LEGv8 IF stage plus IF/ID register. Owns the PC, the fetch FSM,
//           the next-PC mux and (optionally) performance counters.
// Build option : define INSTR_FETCH_PERF_EN to add perf_fetched/perf_bubbles.
// Ports   :
//   clk          in   clock
//   reset        in   synchronous active-high reset
//   stall        in   hold PC and IF/ID (load-use hazard)
//   if_flush     in   squash the word being fetched
//   br_taken     in   branch resolved taken this cycle
//   br_target    in   redirect address, valid with br_taken
//   imem_addr    out  instruction memory address (= PC)
//   imem_rdata   in   instruction at imem_addr (combinational read)
//   ifid_pc      out  PC of the instruction in IF/ID
//   ifid_instr   out  instruction in IF/ID
//   ifid_opcode  out  ifid_instr[31:21]
//   ifid_valid   out  IF/ID holds a real instruction
//   fetch_fault  out  sticky misaligned-branch-target fault
//   perf_fetched out  (INSTR_FETCH_PERF_EN) valid IF/ID writes
//   perf_bubbles out  (INSTR_FETCH_PERF_EN) bubble IF/ID writes
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_BOOT  | first cycle after reset: IF/ID gets a bubble, PC holds
// S_RUN   | normal fetch: branch > stall > flush > sequential
// S_FAULT | misaligned branch target seen: PC frozen, bubbles until reset
// -----------------------------------------------------------------------------
module instr_fetch_stage
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               if_flush,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [10:0]        ifid_opcode,
  output logic               ifid_valid,
`ifdef INSTR_FETCH_PERF_EN
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles,
`endif
  output logic               fetch_fault
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_fault;

  logic w_misaligned;
  logic w_ifid_en;
  logic w_ifid_bubble;

  assign w_misaligned = br_taken && (br_target[1:0] != 2'b00);

  // IF/ID load control; stall is the only case that holds the register
  always_comb begin
    w_ifid_en     = 1'b1;
    w_ifid_bubble = 1'b1;
    if (r_state == S_RUN) begin
      if (br_taken) begin
        w_ifid_bubble = 1'b1;
      end else if (stall) begin
        w_ifid_en = 1'b0;
      end else if (if_flush) begin
        w_ifid_bubble = 1'b1;
      end else begin
        w_ifid_bubble = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_misaligned) begin
            r_fault <= 1'b1;
            r_state <= S_FAULT;
          end else if (br_taken) begin
            r_pc <= br_target;
          end else if (!stall) begin
            // flush and sequential both advance; wraps at 2^ADDR_W
            r_pc <= r_pc + ADDR_W'(PC_INC);
          end
        end
        S_FAULT: begin
          r_state <= S_FAULT;
        end
        default: begin
          r_state <= S_BOOT;
        end
      endcase
    end
  end

  ifid_pipe_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_ifid (
    .clk     (clk),
    .reset   (reset),
    .en      (w_ifid_en),
    .bubble  (w_ifid_bubble),
    .d_pc    (r_pc),
    .d_instr (imem_rdata),
    .q_pc    (ifid_pc),
    .q_instr (ifid_instr),
    .q_valid (ifid_valid)
  );

`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_bubbles;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetched <= '0;
      r_perf_bubbles <= '0;
    end else if (w_ifid_en) begin
      if (w_ifid_bubble) r_perf_bubbles <= r_perf_bubbles + 32'd1;
      else               r_perf_fetched <= r_perf_fetched + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_bubbles = r_perf_bubbles;
`endif

  assign imem_addr   = r_pc;
  assign ifid_opcode = ifid_instr[OPC_MSB:OPC_LSB];
  assign fetch_fault = r_fault;

endmodule : instr_fetch_stage

// File: tb/tb_instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_stage
// Purpose : directed test of instr_fetch_stage. Instruction memory returns
//           {16'hC0DE, addr[15:0]} so every expected word follows from its PC.
// -----------------------------------------------------------------------------
module tb_instr_fetch_stage;

  localparam logic [31:0] NOP = 32'hD503201F;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        if_flush;
  logic        br_taken;
  logic [63:0] br_target;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic [10:0] ifid_opcode;
  logic        ifid_valid;
  logic        fetch_fault;
`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_stage #(
    .ADDR_W   (64),
    .INSTR_W  (32),
    .RESET_PC (64'h0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .if_flush    (if_flush),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .ifid_pc     (ifid_pc),
    .ifid_instr  (ifid_instr),
    .ifid_opcode (ifid_opcode),
    .ifid_valid  (ifid_valid),
`ifdef INSTR_FETCH_PERF_EN
    .perf_fetched(perf_fetched),
    .perf_bubbles(perf_bubbles),
`endif
    .fetch_fault (fetch_fault)
  );

  assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // one clock edge, then settle 1 time unit before driving/sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall     = 1'b0;
    if_flush  = 1'b0;
    br_taken  = 1'b0;
    br_target = 64'h0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();

    // 1: reset state and sequential fetch
    check("rst_addr",  imem_addr,   64'h0);
    check("rst_valid", ifid_valid,  1'b0);
    check("rst_instr", ifid_instr,  NOP);
    check("rst_pc",    ifid_pc,     64'h0);
    check("rst_fault", fetch_fault, 1'b0);
`ifdef INSTR_FETCH_PERF_EN
    check("rst_pf", perf_fetched, 32'd0);
    check("rst_pb", perf_bubbles, 32'd0);
`endif
    reset = 1'b0;
    tick();
    check("boot_valid", ifid_valid, 1'b0);
    check("boot_addr",  imem_addr,  64'h0);
    tick();
    check("f0_pc",    ifid_pc,     64'h0);
    check("f0_instr", ifid_instr,  32'hC0DE0000);
    check("f0_valid", ifid_valid,  1'b1);
    check("f0_opc",   ifid_opcode, 11'h606);
    check("f0_addr",  imem_addr,   64'h4);
    tick();
    check("f1_pc",    ifid_pc,    64'h4);
    check("f1_instr", ifid_instr, 32'hC0DE0004);
    tick();
    check("f2_pc",    ifid_pc,    64'h8);
    check("f2_instr", ifid_instr, 32'hC0DE0008);
    tick();
    check("f3_pc",    ifid_pc,    64'hC);
    check("f3_addr",  imem_addr,  64'h10);

    // 2: stall two cycles at pc=0x10
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stl_addr",  imem_addr,  64'h10);
      check("stl_pc",    ifid_pc,    64'hC);
      check("stl_instr", ifid_instr, 32'hC0DE000C);
      check("stl_valid", ifid_valid, 1'b1);
    end
    stall = 1'b0;
    tick();
    check("rel_pc",   ifid_pc,   64'h10);
    check("rel_addr", imem_addr, 64'h14);

    // 3: branch overrides stall
    br_taken  = 1'b1;
    br_target = 64'h100;
    stall     = 1'b1;
    tick();
    idle_inputs();
    check("br_addr",  imem_addr,  64'h100);
    check("br_valid", ifid_valid, 1'b0);
    check("br_instr", ifid_instr, NOP);
    check("br_pc",    ifid_pc,    64'h10);
    tick();
    check("br1_pc",    ifid_pc,    64'h100);
    check("br1_instr", ifid_instr, 32'hC0DE0100);
    check("br1_valid", ifid_valid, 1'b1);
    check("br1_addr",  imem_addr,  64'h104);

    // 4: flush at pc=0x20, then flush under stall
    br_taken  = 1'b1;
    br_target = 64'h20;
    tick();
    idle_inputs();
    check("to20_addr", imem_addr, 64'h20);
    if_flush = 1'b1;
    tick();
    check("fl_valid", ifid_valid, 1'b0);
    check("fl_instr", ifid_instr, NOP);
    check("fl_addr",  imem_addr,  64'h24);
    if_flush = 1'b0;
    tick();
    check("pf_pc", ifid_pc, 64'h24);
    if_flush = 1'b1;
    stall    = 1'b1;
    tick();
    idle_inputs();
    check("fs_valid", ifid_valid, 1'b1);
    check("fs_instr", ifid_instr, 32'hC0DE0024);
    check("fs_addr",  imem_addr,  64'h28);

    // 5: misaligned target fault, then reset out of it
    br_taken  = 1'b1;
    br_target = 64'h102;
    tick();
    idle_inputs();
    check("flt_fault", fetch_fault, 1'b1);
    check("flt_addr",  imem_addr,   64'h28);
    check("flt_valid", ifid_valid,  1'b0);
    br_taken  = 1'b1;
    br_target = 64'h200;
    tick();
    tick();
    idle_inputs();
    check("flt2_addr",  imem_addr,   64'h28);
    check("flt2_valid", ifid_valid,  1'b0);
    check("flt2_fault", fetch_fault, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("frst_addr",  imem_addr,   64'h0);
    check("frst_fault", fetch_fault, 1'b0);
    tick();
    check("frst_boot", ifid_valid, 1'b0);
    check("frst_badr", imem_addr,  64'h0);
    tick();
    check("frst_f0", ifid_valid, 1'b1);
    check("frst_pc", ifid_pc,    64'h0);

    // PC increment wraps without faulting
    br_taken  = 1'b1;
    br_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    idle_inputs();
    tick();
    check("wrap_addr",  imem_addr,   64'h0);
    check("wrap_pc",    ifid_pc,     64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_fault", fetch_fault, 1'b0);

`ifdef INSTR_FETCH_PERF_EN
    // 6: 10 edges after reset: boot, 6 fetches, 1 flush, 2 stalls
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("pr_pf", perf_fetched, 32'd0);
    for (int c = 0; c < 10; c++) begin
      idle_inputs();
      if (c == 3) if_flush = 1'b1;
      if (c == 5 || c == 6) stall = 1'b1;
      tick();
    end
    idle_inputs();
    check("perf_fetched", perf_fetched, 32'd6);
    check("perf_bubbles", perf_bubbles, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_instr_fetch_stage
